// File: rtl/rr_vc_arbiter.sv
// Round-robin virtual-channel arbiter for one output port of the mesh switch.
// A grant is held for a whole packet; on release the pointer moves just past the winner.
module rr_vc_arbiter #(
    parameter int NUM_VC = 4,
    parameter int NUM_VN = 3,
    localparam int bits_VC = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic               clk,
    input  logic               rst_p,
    input  logic [NUM_VC-1:0]  req_in,
    input  logic               grant_en,
    input  logic               tail_in,
    output logic [NUM_VC-1:0]  grant_out,
    output logic               grant_vld,
    output logic [bits_VC-1:0] grant_id,
    output logic [bits_VC-1:0] ptr_out
);

    localparam int IW = bits_VC + 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    generate
        if (NUM_VC < 2 || NUM_VN < 1) begin : g_bad_param
            $error("rr_vc_arbiter: NUM_VC must be >= 2 and NUM_VN >= 1");
        end
    endgenerate

    // First requester at or after ptr, wrapping explicitly so non-power-of-two counts work.
    function automatic logic [bits_VC-1:0] pick_winner(
        input logic [NUM_VC-1:0]  req,
        input logic [bits_VC-1:0] ptr
    );
        logic [IW-1:0]      idx;
        logic [bits_VC-1:0] win;
        win = {bits_VC{1'b0}};
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + IW'(k);
            if (idx >= IW'(NUM_VC)) begin
                idx = idx - IW'(NUM_VC);
            end
            if (req[idx[bits_VC-1:0]]) begin
                win = idx[bits_VC-1:0];
            end
        end
        return win;
    endfunction

    function automatic logic [bits_VC-1:0] next_ptr(input logic [bits_VC-1:0] id);
        if (id == bits_VC'(NUM_VC - 1)) begin
            return {bits_VC{1'b0}};
        end else begin
            return id + {{(bits_VC-1){1'b0}}, 1'b1};
        end
    endfunction

    state_t             r_state;
    logic [NUM_VC-1:0]  r_grant_out;
    logic               r_grant_vld;
    logic [bits_VC-1:0] r_grant_id;
    logic [bits_VC-1:0] r_ptr;

    state_t             w_state_nxt;
    logic [NUM_VC-1:0]  w_grant_nxt;
    logic               w_vld_nxt;
    logic [bits_VC-1:0] w_id_nxt;
    logic [bits_VC-1:0] w_ptr_nxt;

    logic [bits_VC-1:0] w_ptr_rel;
    logic [bits_VC-1:0] w_search_ptr;
    logic [bits_VC-1:0] w_winner;
    logic [NUM_VC-1:0]  w_onehot;
    logic               w_any_req;
    logic               w_release;

    // In the release cycle the search already starts past the finishing VC.
    assign w_ptr_rel    = next_ptr(r_grant_id);
    assign w_search_ptr = (r_state == ST_LOCKED) ? w_ptr_rel : r_ptr;
    assign w_winner     = pick_winner(req_in, w_search_ptr);
    assign w_onehot     = {{(NUM_VC-1){1'b0}}, 1'b1} << w_winner;
    assign w_any_req    = |req_in;
    assign w_release    = (grant_en & tail_in) | ~req_in[r_grant_id];

    // Next-state and next-grant decision.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_out;
        w_vld_nxt   = r_grant_vld;
        w_id_nxt    = r_grant_id;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req && grant_en) begin
                    w_state_nxt = ST_LOCKED;
                    w_grant_nxt = w_onehot;
                    w_vld_nxt   = 1'b1;
                    w_id_nxt    = w_winner;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = {NUM_VC{1'b0}};
                    w_vld_nxt   = 1'b0;
                    w_id_nxt    = {bits_VC{1'b0}};
                end
            end
            ST_LOCKED: begin
                if (w_release) begin
                    w_ptr_nxt = w_ptr_rel;
                    if (w_any_req && grant_en) begin
                        w_state_nxt = ST_LOCKED;
                        w_grant_nxt = w_onehot;
                        w_vld_nxt   = 1'b1;
                        w_id_nxt    = w_winner;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = {NUM_VC{1'b0}};
                        w_vld_nxt   = 1'b0;
                        w_id_nxt    = {bits_VC{1'b0}};
                    end
                end else begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = {NUM_VC{1'b0}};
                w_vld_nxt   = 1'b0;
                w_id_nxt    = {bits_VC{1'b0}};
            end
        endcase
    end

    // State, grant and pointer registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_state     <= ST_IDLE;
            r_grant_out <= {NUM_VC{1'b0}};
            r_grant_vld <= 1'b0;
            r_grant_id  <= {bits_VC{1'b0}};
            r_ptr       <= {bits_VC{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_grant_out <= w_grant_nxt;
            r_grant_vld <= w_vld_nxt;
            r_grant_id  <= w_id_nxt;
            r_ptr       <= w_ptr_nxt;
        end
    end

    assign grant_out = r_grant_out;
    assign grant_vld = r_grant_vld;
    assign grant_id  = r_grant_id;
    assign ptr_out   = r_ptr;

endmodule

// File: tb/tb_rr_vc_arbiter.sv
// Bench for rr_vc_arbiter: directed vector table (NUM_VC=4), directed NUM_VC=3
// rotation, then randomized traffic against a behavioural model for both sizes.
module tb_rr_vc_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, en4, tail4, v4;
    logic [3:0] req4, g4;
    logic [1:0] id4, p4;

    logic       rst3, en3, tail3, v3;
    logic [2:0] req3, g3;
    logic [1:0] id3, p3;

    int n_tests = 0;
    int n_fail  = 0;

    rr_vc_arbiter #(.NUM_VC(4), .NUM_VN(3)) dut4 (
        .clk(clk), .rst_p(rst4), .req_in(req4), .grant_en(en4), .tail_in(tail4),
        .grant_out(g4), .grant_vld(v4), .grant_id(id4), .ptr_out(p4)
    );

    rr_vc_arbiter #(.NUM_VC(3), .NUM_VN(3)) dut3 (
        .clk(clk), .rst_p(rst3), .req_in(req3), .grant_en(en3), .tail_in(tail3),
        .grant_out(g3), .grant_vld(v3), .grant_id(id3), .ptr_out(p3)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       en;
        logic       tail;
        logic [3:0] eg;
        logic [1:0] eid;
        logic       ev;
        logic [1:0] ep;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic en,
                                input logic tail, input logic [3:0] eg, input logic [1:0] eid,
                                input logic ev, input logic [1:0] ep);
        vec_t v;
        v.rst = rst; v.req = req; v.en = en; v.tail = tail;
        v.eg = eg; v.eid = eid; v.ev = ev; v.ep = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] ag, input logic av,
                         input logic [1:0] aid, input logic [1:0] ap,
                         input logic [3:0] eg, input logic ev,
                         input logic [1:0] eid, input logic [1:0] ep);
        n_tests++;
        if (ag !== eg || av !== ev || aid !== eid || ap !== ep) begin
            n_fail++;
            $display("FAIL %s: got grant=%b vld=%b id=%0d ptr=%0d, expected grant=%b vld=%b id=%0d ptr=%0d",
                     name, ag, av, aid, ap, eg, ev, eid, ep);
        end
    endtask

    // Behavioural model: held VC (-1 when none) and priority pointer per instance.
    int m_held[2];
    int m_ptr[2];

    function automatic int pick(input int n, input logic [3:0] req, input int ptr);
        for (int k = 0; k < n; k++) begin
            if (req[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    task automatic model_step(input int u, input int n, input logic rst, input logic [3:0] req,
                              input logic en, input logic tail);
        if (rst) begin
            m_held[u] = -1;
            m_ptr[u]  = 0;
        end else if (m_held[u] >= 0) begin
            if ((en && tail) || !req[m_held[u]]) begin
                m_ptr[u]  = (m_held[u] + 1) % n;
                m_held[u] = (en && req != 4'b0000) ? pick(n, req, m_ptr[u]) : -1;
            end
        end else if (en && req != 4'b0000) begin
            m_held[u] = pick(n, req, m_ptr[u]);
        end
    endtask

    function automatic logic [3:0] model_grant(input int u);
        logic [3:0] one;
        one = 4'b0001;
        return (m_held[u] >= 0) ? (one << m_held[u]) : 4'b0000;
    endfunction

    initial begin
        logic [3:0] r4;
        logic [2:0] r3;
        logic [3:0] one;
        one = 4'b0001;
        rst4 = 1'b1; req4 = 4'b0000; en4 = 1'b0; tail4 = 1'b0;
        rst3 = 1'b1; req3 = 3'b000;  en3 = 1'b0; tail3 = 1'b0;

        //                 rst   req      en    tail  grant    id     vld   ptr
        tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 4'b0100, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd3));
        tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 2'd1));
        tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 2'd2));
        tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 2'd3));
        tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 2'd0));
        tbl.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 4'b0010, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 4'b0010, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 4'b0011, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 2'd2));
        tbl.push_back(mk(1'b0, 4'b1001, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 2'd3));
        tbl.push_back(mk(1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd1));
        tbl.push_back(mk(1'b0, 4'b0100, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 2'd1));
        for (int i = 0; i < 5; i++) begin
            tbl.push_back(mk(1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 2'd1));
        end
        tbl.push_back(mk(1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 2'd3));
        tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd3));
        tbl.push_back(mk(1'b0, 4'b1000, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1, 2'd3));
        tbl.push_back(mk(1'b0, 4'b1000, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1, 2'd3));
        tbl.push_back(mk(1'b0, 4'b0110, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd2));
        tbl.push_back(mk(1'b0, 4'b0001, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 2'd2));
        tbl.push_back(mk(1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 4'b0001, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0));

        foreach (tbl[i]) begin
            rst4 = tbl[i].rst; req4 = tbl[i].req; en4 = tbl[i].en; tail4 = tbl[i].tail;
            @(posedge clk); #1;
            check($sformatf("vec4[%0d]", i), g4, v4, id4, p4,
                  tbl[i].eg, tbl[i].ev, tbl[i].eid, tbl[i].ep);
        end

        // NUM_VC = 3 rotation under continuous tails: ids and pointer run 0,1,2,0,...
        @(posedge clk); #1;
        check("vc3_reset", {1'b0, g3}, v3, id3, p3, 4'b0000, 1'b0, 2'd0, 2'd0);
        rst3 = 1'b0; req3 = 3'b111; en3 = 1'b1; tail3 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            check($sformatf("vc3_rot[%0d]", i), {1'b0, g3}, v3, id3, p3,
                  one << (i % 3), 1'b1, 2'(i % 3), 2'(i % 3));
        end

        // Randomized traffic against the behavioural model, both sizes in parallel.
        r4 = 4'b0000;
        r3 = 3'b000;
        for (int i = 0; i < 800; i++) begin
            if (i == 0 || $urandom_range(0, 3) == 0) r4 = 4'($urandom_range(0, 15));
            if (i == 0 || $urandom_range(0, 3) == 0) r3 = 3'($urandom_range(0, 7));
            rst4 = (i == 0) || ($urandom_range(0, 63) == 0);
            rst3 = (i == 0) || ($urandom_range(0, 63) == 0);
            req4 = r4; en4 = ($urandom_range(0, 3) != 0); tail4 = ($urandom_range(0, 2) == 0);
            req3 = r3; en3 = ($urandom_range(0, 3) != 0); tail3 = ($urandom_range(0, 2) == 0);
            model_step(0, 4, rst4, req4, en4, tail4);
            model_step(1, 3, rst3, {1'b0, req3}, en3, tail3);
            @(posedge clk); #1;
            check($sformatf("rand4[%0d]", i), g4, v4, id4, p4, model_grant(0),
                  m_held[0] >= 0, 2'((m_held[0] >= 0) ? m_held[0] : 0), 2'(m_ptr[0]));
            check($sformatf("rand3[%0d]", i), {1'b0, g3}, v3, id3, p3, model_grant(1),
                  m_held[1] >= 0, 2'((m_held[1] >= 0) ? m_held[1] : 0), 2'(m_ptr[1]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_vc_arbiter.md
# rr_vc_arbiter

Round-robin virtual-channel arbiter for one output port of the 2D-mesh VC switch. It selects one of NUM_VC requesting virtual channels, holds the grant for a whole packet, and rotates priority on release. It is the stage directly downstream of the VC rotation logic and owns the priority pointer that drives it. The search order is the request vector rotated so that the pointer position becomes the highest-priority bit.

## Interface
- NUM_VC, 4: number of virtual channels arbitrated; must be ≥ 2; power of two not required.
- NUM_VN, 3: number of virtual networks; carried for parameter compatibility only; no effect on logic.
- bits_VC (localparam): Log2(NUM_VC), from common_functions.vh.

Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on the rising edge.
- rst_p  in  1  synchronous active-high reset.
- req_in  in  NUM_VC  per-VC request; bit i set means VC i has a flit for this port.
- grant_en  in  1  downstream can accept a flit this cycle; a transfer occurs when grant_vld & grant_en.
- tail_in  in  1  flit transferred this cycle is the packet tail; sampled only when a transfer occurs.
- grant_out  out  NUM_VC  registered one-hot grant.
- grant_vld  out  1  registered; equals |grant_out.
- grant_id  out  bits_VC  registered binary index of the granted VC.
- ptr_out  out  bits_VC  current priority pointer, the highest-priority VC index.

## Operation
- State machine with two states, IDLE and LOCKED. Reset enters IDLE.
- Winner selection, combinational:
  - k = smallest offset in 0..NUM_VC-1 with req_in[(ptr+k) mod NUM_VC] set.
  - winner = (ptr+k) mod NUM_VC.
  - Modulo wrap is explicit; the result must be correct for non-power-of-two NUM_VC.
- IDLE:
  - If |req_in and grant_en: register grant_out = onehot(winner), grant_id = winner, grant_vld = 1, and go to LOCKED.
  - Otherwise stay in IDLE with all grant outputs 0.
- LOCKED:
  - Grant outputs hold constant.
  - A release occurs if (grant_en & tail_in), or if req_in[grant_id] = 0 (abort).
  - On release, ptr ← (grant_id+1) mod NUM_VC; from NUM_VC-1 it wraps to 0.
  - In the same cycle, a new winner is computed with the updated pointer, excluding nothing. If the new request set is non-empty and grant_en = 1, the new grant is registered with no bubble and the state stays LOCKED. Otherwise grant outputs clear and the state goes to IDLE.
  - A VC that has just finished a packet has lowest priority in the release cycle, so it wins only if it is the sole requester.
  - Non-tail transfers and cycles with grant_en = 0 leave all state unchanged, except for an abort.
- The pointer changes only on release and never while a grant is held.

## Timing
- Reset values: grant_out = 0, grant_vld = 0, grant_id = 0, ptr_out = 0, state = IDLE.
- Reset has priority over every other event, including mid-packet; any held grant is dropped on the next edge.
- Grant latency: 1 cycle from the edge at which req_in and grant_en are sampled. There is no combinational path from inputs to outputs.
- Release latency: 1 cycle. The grant changes or clears on the edge following the tail or abort cycle.
- Sustained throughput with back-to-back packets is one packet per packet length, with zero idle cycles between packets.
- tail_in while grant_vld = 0, or while grant_en = 0, is ignored.

## Test plan
- Reset and single request, NUM_VC = 4:
  - Stimulus: rst_p high for 2 cycles, then req_in = 0100, grant_en = 1.
  - Required response: one cycle later grant_out = 0100, grant_id = 2, ptr_out = 0.
  - Then tail_in = 1 for one cycle: grant clears and ptr_out = 3.
- Fairness under full load:
  - Stimulus: req_in = 1111 held, tail_in = 1 every transfer.
  - Required response: grant_id sequence 0, 1, 2, 3, 0 with no idle cycle between grants.
- Packet lock:
  - Stimulus: VC1 granted with 3-flit packet; VC0 requests in flit 2.
  - Required response: grant stays on VC1 until tail; then VC0 is not granted before VC2 or VC3 if they request, and VC0 is granted when it is the sole requester.
- Back-pressure:
  - Stimulus: grant_en = 0 for 5 cycles during a packet, with tail_in = 1 asserted throughout.
  - Required response: grant held and ptr unchanged; release occurs only after grant_en returns high together with tail_in.
- Abort and wrap:
  - Stimulus: VC3 granted, then req_in[3] drops.
  - Required response: next cycle ptr_out = 0, and grant moves to the next requester or clears.
- Non-power-of-two, NUM_VC = 3:
  - Stimulus: req_in = 111 under continuous tails.
  - Required response: grant_id cycles 0, 1, 2, 0; ptr_out never reaches 3.
